tsc_param_cache: RTL and testbench

//  Parametrised trigger-surround cache: stores a continuous ADC sample stream in a ring buffer.

---
 rtl/tsc_param_cache_pkg.sv | 32 +++
 rtl/tsc_param_cache_if.sv | 38 +++
 rtl/tsc_param_cache_ring_buf.sv | 39 +++
 rtl/tsc_param_cache.sv | 200 ++++++++++++++++++++
 tb/tb_tsc_param_cache.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsc_param_cache_pkg.sv
// -----------------------------------------------------------------------------
// tsc_param_cache_pkg
// Shared definitions for the trigger-surround cache: FSM state encoding,
// trigger-edge polarity constants and a constant-time clog2 helper used to
// size pointers and counters.
// -----------------------------------------------------------------------------
package tsc_param_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4,
    ST_SEND  = 3'd5
  } tsc_state_t;

  // Value of edge_fall selecting each crossing direction.
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // Ceiling log2, evaluated at elaboration time for parameter sizing.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/tsc_param_cache_if.sv
// -----------------------------------------------------------------------------
// tsc_param_cache_if
// Bundles the sample stream, capture control and readout signals of the
// trigger-surround cache.
//   master : sampler/readout side (drives start, adc_*, thresh, edge_fall,
//            sbf, req; receives trd, cd, rdy, dat, sd, trigtm)
//   slave  : the cache itself
// -----------------------------------------------------------------------------
interface tsc_param_cache_if #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 32
) ();

  logic              start;      // 1-cycle pulse, begin capture
  logic [DATA_W-1:0] adc_data;   // sample, qualified by adc_valid
  logic              adc_valid;  // sample strobe
  logic [DATA_W-1:0] thresh;     // unsigned trigger level
  logic              edge_fall;  // 0 rising, 1 falling crossing
  logic              sbf;        // send-buffer request
  logic              req;        // fetch next word
  logic              trd;        // trigger detected
  logic              cd;         // capture done
  logic              rdy;        // dat valid pulse
  logic [DATA_W-1:0] dat;        // readout word
  logic              sd;         // last word marker
  logic [TS_W-1:0]   trigtm;     // trigger timestamp

  modport master (
    output start, adc_data, adc_valid, thresh, edge_fall, sbf, req,
    input  trd, cd, rdy, dat, sd, trigtm
  );

  modport slave (
    input  start, adc_data, adc_valid, thresh, edge_fall, sbf, req,
    output trd, cd, rdy, dat, sd, trigtm
  );

endinterface

// File: rtl/tsc_param_cache_ring_buf.sv
// -----------------------------------------------------------------------------
// tsc_param_cache_ring_buf
// DEPTH x DATA_W simple dual-port RAM: synchronous write, synchronous
// registered read with one cycle of latency. The read register holds its
// value when re is low.
// Ports:
//   clk, reset      clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr/rdata  read port, rdata valid the cycle after re
// -----------------------------------------------------------------------------
module tsc_param_cache_ring_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tsc_param_cache.sv
// -----------------------------------------------------------------------------
// tsc_param_cache
// Trigger-surround cache. Continuously writes the ADC stream into a ring
// buffer, arms after PRE samples, triggers on a threshold crossing and keeps
// POST samples from the trigger inclusive. On sbf the PRE+POST window is
// streamed out oldest-first, one word per req, with a 1-cycle read latency.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    tsc_param_cache_if.slave (stream, control, readout)
// Build option:
//   TSC_TIMESTAMP_EN  defined   -> free-running ts counter, trigtm latched
//                     undefined -> no counter, trigtm tied to 0
// -----------------------------------------------------------------------------
module tsc_param_cache
  import tsc_param_cache_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int PRE    = 16,
  parameter int POST   = 16,
  parameter int TS_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  tsc_param_cache_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  tsc_state_t        state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     trig_ptr;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     post_cnt;
  logic [CW-1:0]     send_cnt;
  logic [DATA_W-1:0] prev;
  logic              trd_q;
  logic              cd_q;
  logic              rdy_q;
  logic              sd_q;
  logic [DATA_W-1:0] rd_data;

  logic              writing;
  logic              hit;
  logic              trig_fire;
  logic              rd_en;

  // Samples are stored in every capturing state; DONE freezes the buffer.
  assign writing = bus.adc_valid &&
                   (state == ST_FILL || state == ST_ARMED || state == ST_POST);

  // A sample equal to thresh counts as at-or-above the level.
  assign hit = (bus.edge_fall == EDGE_RISE)
             ? ((prev <  bus.thresh) && (bus.adc_data >= bus.thresh))
             : ((prev >= bus.thresh) && (bus.adc_data <  bus.thresh));

  assign trig_fire = (state == ST_ARMED) && bus.adc_valid && hit;

  // Once sd is out the window is exhausted; the state leaves SEND next edge.
  assign rd_en = (state == ST_SEND) && bus.req && !sd_q;

  tsc_param_cache_ring_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ring_buf (
    .clk    (clk),
    .reset  (reset),
    .we     (writing),
    .waddr  (wr_ptr),
    .wdata  (bus.adc_data),
    .re     (rd_en),
    .raddr  (rd_ptr),
    .rdata  (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      trig_ptr <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      send_cnt <= '0;
      prev     <= '0;
      trd_q    <= 1'b0;
      cd_q     <= 1'b0;
      rdy_q    <= 1'b0;
      sd_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      sd_q  <= 1'b0;

      if (writing) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= bus.adc_data;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            trd_q    <= 1'b0;
            cd_q     <= 1'b0;
            state    <= (PRE == 0) ? ST_ARMED : ST_FILL;
          end
        end

        // Pre-load PRE samples so the window is always fully populated.
        ST_FILL: begin
          if (bus.adc_valid) begin
            fill_cnt <= fill_cnt + CW'(1);
            if (fill_cnt == CW'(PRE - 1)) state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          if (trig_fire) begin
            trd_q    <= 1'b1;
            trig_ptr <= wr_ptr;
            post_cnt <= CW'(1);
            if (POST == 1) begin
              cd_q  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (bus.adc_valid) begin
            post_cnt <= post_cnt + CW'(1);
            if (post_cnt == CW'(POST - 1)) begin
              cd_q  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (bus.sbf) begin
            rd_ptr   <= trig_ptr - AW'(PRE);
            send_cnt <= '0;
            state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (sd_q) begin
            trd_q <= 1'b0;
            cd_q  <= 1'b0;
            state <= ST_IDLE;
          end else if (bus.req) begin
            rd_ptr   <= rd_ptr + AW'(1);
            send_cnt <= send_cnt + CW'(1);
            rdy_q    <= 1'b1;
            if (send_cnt == CW'(PRE + POST - 1)) sd_q <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.trd = trd_q;
  assign bus.cd  = cd_q;
  assign bus.rdy = rdy_q;
  assign bus.sd  = sd_q;
  assign bus.dat = rd_data;

`ifdef TSC_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] trigtm_q;

  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // Captures ts of the cycle that presents the trigger sample.
  always_ff @(posedge clk) begin
    if (reset)          trigtm_q <= '0;
    else if (trig_fire) trigtm_q <= ts;
  end

  assign bus.trigtm = trigtm_q;
`else
  assign bus.trigtm = {TS_W{1'b0}};
`endif

endmodule

// File: tb/tb_tsc_param_cache.sv
// -----------------------------------------------------------------------------
// tb_tsc_param_cache
// Directed and randomized bench for tsc_param_cache (DATA_W=8, DEPTH=16,
// PRE=4, POST=4, thresh=100). The expected window is derived from the list
// of samples presented since start: the trigger is the first index >= PRE
// whose crossing against its predecessor matches the selected edge, and the
// window is samples [trig-PRE, trig+POST).
// -----------------------------------------------------------------------------
module tb_tsc_param_cache;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int POST   = 4;
  localparam int TS_W   = 32;
  localparam int WIN    = PRE + POST;
  localparam logic [7:0] THRESH = 8'd100;

  logic clk;
  logic reset;

  tsc_param_cache_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  tsc_param_cache #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PRE    (PRE),
    .POST   (POST),
    .TS_W   (TS_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: counts clocks since the last reset edge.
  logic [31:0] tb_ts;
  always @(posedge clk) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  samp_q[$];
  bit          cur_fall;
  int          trig_idx;
  logic [31:0] exp_ts;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_trig(input bit fall, input logic [7:0] th);
    for (int i = PRE; i < samp_q.size(); i++) begin
      if (!fall && samp_q[i-1] <  th && samp_q[i] >= th) return i;
      if ( fall && samp_q[i-1] >= th && samp_q[i] <  th) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_trigtm();
`ifdef TSC_TIMESTAMP_EN
    return exp_ts;
`else
    return 32'd0;
`endif
  endfunction

  task automatic clear_inputs();
    bus.start     = 1'b0;
    bus.adc_data  = '0;
    bus.adc_valid = 1'b0;
    bus.sbf       = 1'b0;
    bus.req       = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_trd"},    bus.trd,    0);
    check({tag, "_cd"},     bus.cd,     0);
    check({tag, "_rdy"},    bus.rdy,    0);
    check({tag, "_sd"},     bus.sd,     0);
    check({tag, "_dat"},    bus.dat,    0);
    check({tag, "_trigtm"}, bus.trigtm, 0);
    reset = 1'b0;
  endtask

  task automatic start_capture();
    bus.edge_fall = cur_fall;
    bus.thresh    = THRESH;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Feeds samp_q; limit > 0 stops early after that many samples.
  task automatic feed(input bit gaps, input bit poke, input int limit);
    int last;
    int n;
    trig_idx = find_trig(cur_fall, THRESH);
    check("trig_found", (trig_idx >= 0), 1);
    if (trig_idx < 0) return;
    last = trig_idx + POST - 1;
    n    = (limit > 0) ? limit : last + 1;
    for (int i = 0; i < n; i++) begin
      bus.adc_valid = 1'b1;
      bus.adc_data  = samp_q[i];
      if (i == trig_idx) exp_ts = tb_ts;
      @(negedge clk);
      bus.adc_valid = 1'b0;
      check($sformatf("trd_s%0d", i), bus.trd, (i >= trig_idx));
      check($sformatf("cd_s%0d", i),  bus.cd,  (i >= last));
      if (poke && i == PRE + 1) begin
        // start/sbf/req while capturing must all be ignored
        bus.start = 1'b1;
        bus.sbf   = 1'b1;
        bus.req   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sbf   = 1'b0;
        bus.req   = 1'b0;
        check("poke_rdy", bus.rdy, 0);
      end
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (limit <= 0) begin
      // Samples after DONE must not disturb the frozen buffer.
      repeat (3) begin
        bus.adc_valid = 1'b1;
        bus.adc_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      bus.adc_valid = 1'b0;
      check("cd_hold",  bus.cd,  1);
      check("trd_hold", bus.trd, 1);
    end
  endtask

  task automatic readout(input bit held, input bit gaps);
    logic [7:0] w;
    check("trigtm", bus.trigtm, exp_trigtm());
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    check("req_before_sbf_rdy", bus.rdy, 0);
    bus.sbf = 1'b1;
    @(negedge clk);
    bus.sbf = 1'b0;
    if (held) begin
      bus.req = 1'b1;
      for (int k = 0; k < WIN; k++) begin
        w = samp_q[trig_idx - PRE + k];
        @(negedge clk);
        check($sformatf("held_rdy%0d", k), bus.rdy, 1);
        check($sformatf("held_dat%0d", k), bus.dat, w);
        check($sformatf("held_sd%0d", k),  bus.sd,  (k == WIN - 1));
      end
      @(negedge clk);
      bus.req = 1'b0;
      check("held_end_rdy", bus.rdy, 0);
    end else begin
      for (int k = 0; k < WIN; k++) begin
        w = samp_q[trig_idx - PRE + k];
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        check($sformatf("rdy%0d", k), bus.rdy, 1);
        check($sformatf("dat%0d", k), bus.dat, w);
        check($sformatf("sd%0d", k),  bus.sd,  (k == WIN - 1));
      end
      @(negedge clk);
    end
    check("idle_trd", bus.trd, 0);
    check("idle_cd",  bus.cd,  0);
    // Back in IDLE: req is ignored.
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    check("idle_req_rdy", bus.rdy, 0);
    check("idle_req_sd",  bus.sd,  0);
  endtask

  task automatic run_case(input bit gaps, input bit poke, input bit held,
                          input bit rgaps);
    start_capture();
    feed(gaps, poke, 0);
    if (trig_idx >= 0) readout(held, rgaps);
  endtask

  task automatic load_ramp(input bit down);
    samp_q.delete();
    for (int i = 0; i <= 20; i++)
      samp_q.push_back(down ? 8'(200 - 10 * i) : 8'(10 * i));
  endtask

  task automatic load_random();
    int t;
    samp_q.delete();
    while (samp_q.size() < 200) begin
      t = find_trig(cur_fall, THRESH);
      if (t >= 0 && samp_q.size() >= t + POST) break;
      if (t < 0 && samp_q.size() == 40) begin
        samp_q.push_back(cur_fall ? 8'd200 : 8'd0);
        samp_q.push_back(cur_fall ? 8'd0 : 8'd200);
      end else begin
        samp_q.push_back(8'($urandom_range(0, 255)));
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    bus.thresh    = THRESH;
    bus.edge_fall = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    pulse_reset("rst");

    // 1: rising ramp, trigger on 100
    cur_fall = 1'b0;
    load_ramp(1'b0);
    run_case(1'b0, 1'b0, 1'b0, 1'b0);

    // 2: falling ramp, trigger on 90
    cur_fall = 1'b1;
    load_ramp(1'b1);
    run_case(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: pointer wrap, 30 lows then 150
    cur_fall = 1'b0;
    samp_q.delete();
    repeat (30) samp_q.push_back(8'($urandom_range(0, 99)));
    samp_q.push_back(8'd150);
    repeat (3) samp_q.push_back(8'($urandom_range(0, 255)));
    run_case(1'b1, 1'b1, 1'b0, 1'b1);

    // 4: crossing in FILL ignored, first ARMED sample triggers, POST crossings ignored
    samp_q = '{8'd0, 8'd150, 8'd0, 8'd0, 8'd150, 8'd0, 8'd150, 8'd0};
    run_case(1'b0, 1'b0, 1'b0, 1'b0);

    // 5: req held every cycle
    load_ramp(1'b0);
    run_case(1'b0, 1'b0, 1'b1, 1'b0);

    // 6a: reset during POST, then a fresh capture
    load_ramp(1'b0);
    start_capture();
    feed(1'b0, 1'b0, 12);
    pulse_reset("rst_post");
    run_case(1'b0, 1'b0, 1'b0, 1'b0);

    // 6b: reset during SEND, then a fresh capture
    cur_fall = 1'b1;
    load_ramp(1'b1);
    start_capture();
    feed(1'b0, 1'b0, 0);
    bus.sbf = 1'b1;
    @(negedge clk);
    bus.sbf = 1'b0;
    bus.req = 1'b1;
    repeat (3) @(negedge clk);
    pulse_reset("rst_send");
    run_case(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized captures
    for (int r = 0; r < 8; r++) begin
      cur_fall = 1'($urandom_range(0, 1));
      load_random();
      run_case(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
